// File: rtl/pipe_stage_q_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_q_pkg
// Shared instruction-id definitions for in-order front-end structures
// (stage buffers, ROB, branch queue).
//   id_t          : default-width instruction id
//   wide_id_t     : container wide enough for any supported id width
//   id_is_younger : modular age comparison for ids of a given width
// -----------------------------------------------------------------------------
package pipe_stage_q_pkg;

   localparam int unsigned MAX_ID_W = 32;
   localparam int unsigned DEF_ID_W = 8;

   typedef logic [DEF_ID_W-1:0] id_t;
   typedef logic [MAX_ID_W-1:0] wide_id_t;

   // a is younger than b when (a-b) mod 2^w is non-zero with its MSB clear.
   // Callers zero-extend their ids into wide_id_t and pass their own width w.
   function automatic logic id_is_younger(input wide_id_t a, input wide_id_t b,
                                          input int unsigned w);
      wide_id_t mask;
      wide_id_t diff;
      mask = {MAX_ID_W{1'b1}} >> (MAX_ID_W - w);
      diff = (a - b) & mask;
      return (diff != '0) && (((diff >> (w - 1)) & wide_id_t'(1)) == '0);
   endfunction

endpackage

// File: rtl/pipe_stage_q_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_q_if
// Handshake bundle of a pipe_stage_q: upstream push side, downstream pop side
// and the squash/flush controls.
//   master : producer/consumer/control side (drives valid, data, ready, kills)
//   slave  : the buffer itself
// -----------------------------------------------------------------------------
interface pipe_stage_q_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [ID_W-1:0]   in_id;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ID_W-1:0]   out_id;
   logic              squash_valid;
   logic [ID_W-1:0]   squash_id;
   logic              flush;

   modport master (
      output in_valid, in_data, in_id, out_ready, squash_valid, squash_id, flush,
      input  in_ready, out_valid, out_data, out_id
   );

   modport slave (
      input  in_valid, in_data, in_id, out_ready, squash_valid, squash_id, flush,
      output in_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/pipe_stage_q_kill.sv
// -----------------------------------------------------------------------------
// pipe_stage_q_kill
// Combinational squash evaluation over the buffer contents viewed from head.
//   occ          : occupancy mask, bit i = entry head+i present
//   ids          : ids of the entries, index 0 = head
//   squash_valid : selective squash request
//   squash_id    : squashing id (survives; strictly younger ids die)
//   flush        : kill everything
//   surv_cnt     : number of entries remaining after the kill
//   head_kill    : the head entry is killed this cycle
// -----------------------------------------------------------------------------
module pipe_stage_q_kill
   import pipe_stage_q_pkg::*;
#(
   parameter  int unsigned ID_W  = 8,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0] occ,
   input  logic [ID_W-1:0]  ids [DEPTH],
   input  logic [ID_W-1:0]  squash_id,
   input  logic             squash_valid,
   input  logic             flush,
   output logic [CNT_W-1:0] surv_cnt,
   output logic             head_kill
);

   // Entries are held in id order, so the survivors form a prefix: count
   // leading occupied entries until the first one younger than squash_id.
   always_comb begin
      logic alive;
      logic young;
      surv_cnt  = '0;
      head_kill = 1'b0;
      alive     = 1'b1;
      young     = 1'b0;
      if (flush) begin
         head_kill = occ[0];
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            young = squash_valid &&
                    id_is_younger(wide_id_t'(ids[i]), wide_id_t'(squash_id), ID_W);
            if (alive && occ[i] && !young) begin
               surv_cnt = surv_cnt + CNT_W'(1);
            end else begin
               alive = 1'b0;
            end
         end
         head_kill = occ[0] && squash_valid &&
                     id_is_younger(wide_id_t'(ids[0]), wide_id_t'(squash_id), ID_W);
      end
   end

endmodule

// File: rtl/pipe_stage_q.sv
// -----------------------------------------------------------------------------
// pipe_stage_q
// Elastic in-order pipeline buffer of DEPTH entries with selective squash and
// full flush, used between front-end stages in place of a stage register.
//   clk, rstn : clock, synchronous active-low reset
//   q         : pipe_stage_q_if.slave (push side, pop side, squash, flush)
//   count_o   : registered occupancy
// Optional build macro PIPE_Q_BYPASS_EN: an empty buffer forwards an incoming
// entry straight to the outputs when downstream is ready (0-cycle latency).
// Without it there is no combinational in->out path.
// -----------------------------------------------------------------------------
module pipe_stage_q
   import pipe_stage_q_pkg::*;
#(
   parameter  int unsigned DATA_W = 64,
   parameter  int unsigned ID_W   = 8,
   parameter  int unsigned DEPTH  = 2,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   pipe_stage_q_if.slave    q,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ID_W-1:0]   id_q   [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_ptr;

   logic [DEPTH-1:0]  occ;
   logic [ID_W-1:0]   ids_ord [DEPTH];
   logic [CNT_W-1:0]  surv_cnt;
   logic              head_kill;

   logic              in_killed;
   logic              push;
   logic              keep;
   logic              stored_valid;
   logic              pop;
   logic              bypass;

   // Pointer advance with explicit wrap; p < DEPTH and n <= DEPTH.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [CNT_W-1:0] n);
      int unsigned s;
      s = 32'(p) + 32'(n);
      if (s >= DEPTH) s = s - DEPTH;
      return PTR_W'(s);
   endfunction

   // Contents viewed from head for the kill evaluation.
   always_comb begin
      occ = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         occ[i]     = CNT_W'(i) < count_q;
         ids_ord[i] = id_q[ptr_add(head_q, CNT_W'(i))];
      end
   end

   pipe_stage_q_kill #(
      .ID_W  (ID_W),
      .DEPTH (DEPTH)
   ) u_kill (
      .occ          (occ),
      .ids          (ids_ord),
      .squash_id    (q.squash_id),
      .squash_valid (q.squash_valid),
      .flush        (q.flush),
      .surv_cnt     (surv_cnt),
      .head_kill    (head_kill)
   );

   // Handshake and kill qualification of the incoming entry.
   assign q.in_ready = (count_q < CNT_W'(DEPTH)) && rstn;
   assign push       = q.in_valid && q.in_ready;
   assign in_killed  = q.flush ||
                       (q.squash_valid &&
                        id_is_younger(wide_id_t'(q.in_id), wide_id_t'(q.squash_id), ID_W));

   // Head is masked in the cycle it is killed, so a pop never removes a victim.
   assign stored_valid = rstn && (count_q != '0) && !q.flush && !head_kill;

`ifdef PIPE_Q_BYPASS_EN
   assign bypass = rstn && (count_q == '0) && q.in_valid && q.out_ready && !in_killed;
`else
   assign bypass = 1'b0;
`endif

   assign q.out_valid = stored_valid || bypass;
   assign q.out_data  = bypass ? q.in_data : data_q[head_q];
   assign q.out_id    = bypass ? q.in_id   : id_q[head_q];

   assign pop     = stored_valid && q.out_ready;
   assign keep    = push && !in_killed && !bypass;
   assign count_o = count_q;

   // Next pointers/count: flush, else squash truncation, then pop and push.
   always_comb begin
      logic [CNT_W-1:0] base_cnt;
      logic [PTR_W-1:0] base_tail;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wr_en     = 1'b0;
      wr_ptr    = tail_q;
      base_cnt  = count_q;
      base_tail = tail_q;
      if (q.squash_valid) begin
         base_cnt  = surv_cnt;
         base_tail = ptr_add(head_q, surv_cnt);
      end
      if (q.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         count_d = base_cnt;
         tail_d  = base_tail;
         wr_ptr  = base_tail;
         if (pop) begin
            head_d  = ptr_add(head_q, CNT_W'(1));
            count_d = count_d - CNT_W'(1);
         end
         if (keep) begin
            wr_en   = 1'b1;
            tail_d  = ptr_add(base_tail, CNT_W'(1));
            count_d = count_d + CNT_W'(1);
         end
      end
   end

   // Control state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_ptr] <= q.in_data;
         id_q[wr_ptr]   <= q.in_id;
      end
   end

endmodule

// File: tb/tb_pipe_stage_q.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_q
// Bench for pipe_stage_q: a DEPTH=2 and a DEPTH=4 instance, directed scenarios
// followed by randomized traffic against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_q;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] data;
   } ent_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] cnt2;
   logic [2:0] cnt4;
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   pipe_stage_q_if #(.DATA_W(64), .ID_W(8)) if2 ();
   pipe_stage_q_if #(.DATA_W(64), .ID_W(8)) if4 ();

   pipe_stage_q #(.DATA_W(64), .ID_W(8), .DEPTH(2)) u2 (
      .clk(clk), .rstn(rstn), .q(if2.slave), .count_o(cnt2));
   pipe_stage_q #(.DATA_W(64), .ID_W(8), .DEPTH(4)) u4 (
      .clk(clk), .rstn(rstn), .q(if4.slave), .count_o(cnt4));

   function automatic logic [63:0] dat(input logic [7:0] id);
      return {24'hC0FFEE, 32'h0, id};
   endfunction

   // Age rule from plain modular arithmetic.
   function automatic bit younger(input logic [7:0] a, input logic [7:0] b);
      int d;
      d = (int'(a) - int'(b) + 256) % 256;
      return (d != 0) && (d < 128);
   endfunction

   task automatic idle();
      if2.in_valid = 0; if2.in_data = '0; if2.in_id = '0; if2.out_ready = 0;
      if2.squash_valid = 0; if2.squash_id = '0; if2.flush = 0;
      if4.in_valid = 0; if4.in_data = '0; if4.in_id = '0; if4.out_ready = 0;
      if4.squash_valid = 0; if4.squash_id = '0; if4.flush = 0;
   endtask

   task automatic push4(input logic [7:0] id);
      @(negedge clk);
      if4.in_valid = 1; if4.in_id = id; if4.in_data = dat(id);
      @(posedge clk);
      #1 if4.in_valid = 0;
   endtask

   task automatic test_reset();
      rstn = 0;
      idle();
      if2.in_valid = 1; if4.in_valid = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (if2.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready2 got=%b exp=0", if2.in_ready); end
      checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready4 got=%b exp=0", if4.in_ready); end
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cnt4); end
      checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", if4.out_valid); end
      idle();
      rstn = 1;
      #1;
      checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", if4.in_ready); end
   endtask

   task automatic test_fill_drain();
      @(negedge clk);
      if2.out_ready = 0; if2.in_valid = 1; if2.in_id = 8'd3; if2.in_data = dat(8'd3);
      #1;
      checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL fd_ready0 got=%b exp=1", if2.in_ready); end
      @(negedge clk);
      if2.in_id = 8'd4; if2.in_data = dat(8'd4);
      #1;
      checks++; if (if2.out_valid !== 1'b1 || if2.out_id !== 8'd3) begin failures++; $display("FAIL fd_head3 got=%b/%0d exp=1/3", if2.out_valid, if2.out_id); end
      checks++; if (cnt2 !== 2'd1) begin failures++; $display("FAIL fd_cnt1 got=%0d exp=1", cnt2); end
      @(negedge clk);
      if2.in_id = 8'd5; if2.in_data = dat(8'd5);
      #1;
      checks++; if (if2.in_ready !== 1'b0 || cnt2 !== 2'd2) begin failures++; $display("FAIL fd_full got=%b/%0d exp=0/2", if2.in_ready, cnt2); end
      @(negedge clk);
      if2.out_ready = 1;
      #1;
      checks++; if (if2.out_id !== 8'd3 || if2.in_ready !== 1'b0) begin failures++; $display("FAIL fd_pop3 got=%0d/%b exp=3/0", if2.out_id, if2.in_ready); end
      @(negedge clk);
      #1;
      checks++; if (if2.out_id !== 8'd4 || cnt2 !== 2'd1 || if2.in_ready !== 1'b1) begin failures++; $display("FAIL fd_pop4 got=%0d/%0d/%b exp=4/1/1", if2.out_id, cnt2, if2.in_ready); end
      @(negedge clk);
      if2.in_valid = 0;
      #1;
      checks++; if (if2.out_valid !== 1'b1 || if2.out_id !== 8'd5 || if2.out_data !== dat(8'd5)) begin failures++; $display("FAIL fd_pop5 got=%b/%0d exp=1/5", if2.out_valid, if2.out_id); end
      @(negedge clk);
      #1;
      checks++; if (if2.out_valid !== 1'b0 || cnt2 !== 2'd0) begin failures++; $display("FAIL fd_empty got=%b/%0d exp=0/0", if2.out_valid, cnt2); end
      if2.out_ready = 0;
   endtask

   task automatic test_selective_squash();
      push4(8'd10); push4(8'd11); push4(8'd12);
      @(negedge clk);
      if4.squash_valid = 1; if4.squash_id = 8'd10;
      #1;
      checks++; if (if4.out_valid !== 1'b1 || if4.out_id !== 8'd10 || cnt4 !== 3'd3) begin failures++; $display("FAIL sq_req got=%b/%0d/%0d exp=1/10/3", if4.out_valid, if4.out_id, cnt4); end
      @(negedge clk);
      if4.squash_valid = 0;
      #1;
      checks++; if (cnt4 !== 3'd1 || if4.out_id !== 8'd10) begin failures++; $display("FAIL sq_after got=%0d/%0d exp=1/10", cnt4, if4.out_id); end
      if4.out_ready = 1;
      @(negedge clk);
      #1;
      checks++; if (cnt4 !== 3'd0 || if4.out_valid !== 1'b0) begin failures++; $display("FAIL sq_drain got=%0d/%b exp=0/0", cnt4, if4.out_valid); end
      if4.out_ready = 0;
   endtask

   task automatic test_squash_push();
      push4(8'd20); push4(8'd21);
      @(negedge clk);
      if4.in_valid = 1; if4.in_id = 8'd22; if4.in_data = dat(8'd22);
      if4.squash_valid = 1; if4.squash_id = 8'd21;
      #1;
      checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("FAIL sp_hs got=%b exp=1", if4.in_ready); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt4 !== 3'd2 || if4.out_id !== 8'd20) begin failures++; $display("FAIL sp_keep got=%0d/%0d exp=2/20", cnt4, if4.out_id); end
      if4.out_ready = 1;
      @(negedge clk);
      #1;
      checks++; if (if4.out_id !== 8'd21 || cnt4 !== 3'd1) begin failures++; $display("FAIL sp_second got=%0d/%0d exp=21/1", if4.out_id, cnt4); end
      @(negedge clk);
      #1;
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL sp_drain got=%0d exp=0", cnt4); end
      if4.out_ready = 0;
   endtask

   task automatic test_wrap_id();
      push4(8'd254); push4(8'd255); push4(8'd0);
      @(negedge clk);
      if4.squash_valid = 1; if4.squash_id = 8'd255;
      #1;
      checks++; if (cnt4 !== 3'd3 || if4.out_valid !== 1'b1) begin failures++; $display("FAIL wr_pre got=%0d/%b exp=3/1", cnt4, if4.out_valid); end
      @(negedge clk);
      if4.squash_valid = 0;
      #1;
      checks++; if (cnt4 !== 3'd2 || if4.out_id !== 8'd254) begin failures++; $display("FAIL wr_post got=%0d/%0d exp=2/254", cnt4, if4.out_id); end
      if4.out_ready = 1;
      @(negedge clk);
      #1;
      checks++; if (if4.out_id !== 8'd255) begin failures++; $display("FAIL wr_second got=%0d exp=255", if4.out_id); end
      @(negedge clk);
      #1;
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL wr_drain got=%0d exp=0", cnt4); end
      if4.out_ready = 0;
   endtask

   task automatic test_flush();
      for (int i = 30; i < 34; i++) push4(8'(i));
      @(negedge clk);
      if4.out_ready = 1; if4.in_valid = 1; if4.in_id = 8'd34; if4.in_data = dat(8'd34);
      if4.flush = 1;
      #1;
      checks++; if (if4.out_valid !== 1'b0 || cnt4 !== 3'd4) begin failures++; $display("FAIL fl_req got=%b/%0d exp=0/4", if4.out_valid, cnt4); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt4 !== 3'd0 || if4.out_valid !== 1'b0) begin failures++; $display("FAIL fl_after got=%0d/%b exp=0/0", cnt4, if4.out_valid); end
      push4(8'd40);
      @(negedge clk);
      #1;
      checks++; if (if4.out_valid !== 1'b1 || if4.out_id !== 8'd40 || if4.out_data !== dat(8'd40)) begin failures++; $display("FAIL fl_refill got=%b/%0d exp=1/40", if4.out_valid, if4.out_id); end
      if4.out_ready = 1;
      @(negedge clk);
      #1;
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL fl_drain got=%0d exp=0", cnt4); end
      if4.out_ready = 0;
   endtask

   task automatic test_latency();
      @(negedge clk);
      if4.in_valid = 1; if4.in_id = 8'd7; if4.in_data = dat(8'd7); if4.out_ready = 1;
      #1;
`ifdef PIPE_Q_BYPASS_EN
      checks++; if (if4.out_valid !== 1'b1 || if4.out_id !== 8'd7) begin failures++; $display("FAIL lat_same got=%b/%0d exp=1/7", if4.out_valid, if4.out_id); end
`else
      checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL lat_same got=%b exp=0", if4.out_valid); end
`endif
      @(negedge clk);
      if4.in_valid = 0;
      #1;
`ifdef PIPE_Q_BYPASS_EN
      checks++; if (cnt4 !== 3'd0 || if4.out_valid !== 1'b0) begin failures++; $display("FAIL lat_next got=%0d/%b exp=0/0", cnt4, if4.out_valid); end
`else
      checks++; if (cnt4 !== 3'd1 || if4.out_valid !== 1'b1 || if4.out_id !== 8'd7) begin failures++; $display("FAIL lat_next got=%0d/%b/%0d exp=1/1/7", cnt4, if4.out_valid, if4.out_id); end
`endif
      @(negedge clk);
      #1;
      checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL lat_drain got=%0d exp=0", cnt4); end
      if4.out_ready = 0;
   endtask

   task automatic test_random();
      ent_t       mq[$];
      ent_t       e;
      logic [7:0] next_id = 8'd250;
      bit         in_k, e_in_ready, e_byp, e_stored, e_valid;
      int         pct, k;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         pct               = ((cyc / 64) % 2 != 0) ? 80 : 30;
         rstn              = ($urandom_range(0, 199) != 0);
         if4.in_valid      = $urandom_range(0, 1) != 0;
         if4.in_id         = next_id;
         if4.in_data       = {$urandom, $urandom};
         if4.out_ready     = $urandom_range(0, 99) < pct;
         if4.flush         = $urandom_range(0, 39) == 0;
         if4.squash_valid  = $urandom_range(0, 7) == 0;
         if4.squash_id     = next_id - 8'($urandom_range(0, 6));
         #1;
         in_k       = if4.flush || (if4.squash_valid && younger(if4.in_id, if4.squash_id));
         e_in_ready = rstn && (mq.size() < 4);
         e_byp      = 1'b0;
`ifdef PIPE_Q_BYPASS_EN
         e_byp      = rstn && (mq.size() == 0) && if4.in_valid && if4.out_ready && !in_k;
`endif
         e_stored   = rstn && (mq.size() != 0) && !if4.flush &&
                      !(if4.squash_valid && younger(mq[0].id, if4.squash_id));
         e_valid    = e_stored || e_byp;
         checks++; if (if4.in_ready !== e_in_ready) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, if4.in_ready, e_in_ready); end
         checks++; if (if4.out_valid !== e_valid) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, if4.out_valid, e_valid); end
         checks++; if (cnt4 !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, cnt4, mq.size()); end
         if (e_valid) begin
            e = e_byp ? ent_t'{id: if4.in_id, data: if4.in_data} : mq[0];
            checks++; if (if4.out_id !== e.id || if4.out_data !== e.data) begin failures++; $display("FAIL rnd_head cyc=%0d got=%0d/%h exp=%0d/%h", cyc, if4.out_id, if4.out_data, e.id, e.data); end
         end
         if (!rstn || if4.flush) begin
            mq.delete();
         end else begin
            if (if4.squash_valid) begin
               k = 0;
               while (k < mq.size() && !younger(mq[k].id, if4.squash_id)) k++;
               while (mq.size() > k) void'(mq.pop_back());
            end
            if (e_stored && if4.out_ready) void'(mq.pop_front());
            if (if4.in_valid && e_in_ready && !in_k && !e_byp)
               mq.push_back(ent_t'{id: if4.in_id, data: if4.in_data});
         end
         if (if4.in_valid && e_in_ready) next_id = next_id + 8'd1;
      end
      @(negedge clk);
      rstn = 1;
      idle();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_selective_squash();
      test_squash_push();
      test_wrap_id();
      test_flush();
      test_latency();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
